// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - parametrised four-phase multi-cycle CPU core
//
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   run              1 = fetch new instructions, 0 = stall in FETCH
//   imem_addr/data   program address (= pc) and combinational instruction return
//   dbg_idx/we/wdata debug register preload, honoured in FETCH when stalled or halted
//   dbg_rdata        combinational readback of regs[dbg_idx]
//   phase            one-hot {WB,EXEC,DEC,FETCH}
//   pc, result       program counter, last ALU result
//   flag_z, flag_c   zero and carry/borrow flags
//   retired          high for the WB cycle of every instruction
//   halted           set by HALT, cleared only by reset
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int RIDX_W = $clog2(NREGS),
  parameter int PC_W   = 4,
  parameter int INST_W = 4 + 3 * RIDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic [RIDX_W-1:0] dbg_idx,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [3:0]        phase,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              retired,
  output logic              halted
);

  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_DEC   = 4'b0010,
    S_EXEC  = 4'b0100,
    S_WB    = 4'b1000
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic                z_q, z_d, c_q, c_d, halted_q, halted_d;
  logic [DATA_W-1:0]   regs_q [NREGS];

  logic                rf_we;
  logic [RIDX_W-1:0]   rf_widx;
  logic [DATA_W-1:0]   rf_wdata;

  logic [3:0]          op;
  logic [RIDX_W-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0]   imm;
  logic [PC_W-1:0]     tgt;
  logic [DATA_W:0]     sum, diff;

  assign op  = ir_q[INST_W-1 -: 4];
  assign rd  = ir_q[3*RIDX_W-1 -: RIDX_W];
  assign rs1 = ir_q[2*RIDX_W-1 -: RIDX_W];
  assign rs2 = ir_q[RIDX_W-1:0];
  // Size casts give zero-extension or truncation for any parameter mix.
  assign imm = DATA_W'({rs1, rs2});
  assign tgt = PC_W'({rd, rs1, rs2});

  // Extra top bit carries the ADD carry-out / SUB borrow (a < b).
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_widx  = rd;
    rf_wdata = result_q;

    case (state_q)
      S_FETCH: begin
        if (run && !halted_q) begin
          ir_d    = imem_data;
          state_d = S_DEC;
        end else if (dbg_we) begin
          // Stalled FETCH is the only window for debug writes, so they
          // never meet a WB write on the register file port.
          rf_we    = 1'b1;
          rf_widx  = dbg_idx;
          rf_wdata = dbg_wdata;
        end
      end
      S_DEC: begin
        a_d     = regs_q[rs1];
        b_d     = regs_q[rs2];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op)
          OP_ADD: begin result_d = sum[DATA_W-1:0];  c_d = sum[DATA_W];  end
          OP_SUB: begin result_d = diff[DATA_W-1:0]; c_d = diff[DATA_W]; end
          OP_AND: result_d = a_q & b_q;
          OP_OR:  result_d = a_q | b_q;
          OP_XOR: result_d = a_q ^ b_q;
          OP_SHL: begin result_d = {a_q[DATA_W-2:0], 1'b0}; c_d = a_q[DATA_W-1]; end
          OP_SHR: begin result_d = {1'b0, a_q[DATA_W-1:1]}; c_d = a_q[0];        end
          OP_LDI: result_d = imm;
          OP_MOV: result_d = a_q;
          default: ;
        endcase
        if (op >= OP_ADD && op <= OP_SHR) z_d = (result_d == '0);
      end
      S_WB: begin
        state_d = S_FETCH;
        if ((op >= OP_ADD && op <= OP_LDI) || op == OP_MOV) rf_we = 1'b1;
        case (op)
          OP_JMP:  pc_d = tgt;
          OP_BZ:   pc_d = z_q ? tgt : pc_q + PC_W'(1);
          OP_HALT: halted_d = 1'b1;
          default: pc_d = pc_q + PC_W'(1);
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      halted_q <= halted_d;
      if (rf_we) regs_q[rf_widx] <= rf_wdata;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign phase     = state_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign retired   = (state_q == S_WB);
  assign halted    = halted_q;
  assign dbg_rdata = regs_q[dbg_idx];

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - directed and randomised checks of cpu_multicycle against an ISA-level model
module tb_cpu_multicycle;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] imem_addr;
  logic [9:0] imem_data;
  logic [1:0] dbg_idx;
  logic       dbg_we;
  logic [7:0] dbg_wdata;
  logic [7:0] dbg_rdata;
  logic [3:0] phase;
  logic [3:0] pc;
  logic [7:0] result;
  logic       flag_z, flag_c, retired, halted;

  logic [9:0] imem [16];
  assign imem_data = imem[imem_addr];

  cpu_multicycle dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dbg_idx(dbg_idx), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .phase(phase), .pc(pc), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .retired(retired), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ISA-level reference state
  int mregs [4];
  int mpc, mres, mz, mc, mhalt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    mpc = 0; mres = 0; mz = 0; mc = 0; mhalt = 0;
  endtask

  task automatic model_exec(input logic [9:0] inst);
    int op, rd, rs1, rs2, a, b, s, tg;
    bit wr;
    op = inst[9:6]; rd = inst[5:4]; rs1 = inst[3:2]; rs2 = inst[1:0];
    a = mregs[rs1]; b = mregs[rs2];
    tg = (rd * 16 + rs1 * 4 + rs2) % 16;
    wr = 0;
    case (op)
      1: begin s = a + b; mres = s % 256; mc = (s > 255); end
      2: begin mres = (a - b + 256) % 256; mc = (a < b); end
      3: mres = a & b;
      4: mres = a | b;
      5: mres = a ^ b;
      6: begin mres = (a * 2) % 256; mc = (a >= 128); end
      7: begin mres = a / 2; mc = a % 2; end
      8: mres = rs1 * 4 + rs2;
      11: mres = a;
      default: ;
    endcase
    if (op >= 1 && op <= 7) mz = (mres == 0);
    if ((op >= 1 && op <= 8) || op == 11) wr = 1;
    if (wr) mregs[rd] = mres;
    if (op == 9 || (op == 10 && mz == 1)) mpc = tg;
    else if (op == 15) mhalt = 1;
    else mpc = (mpc + 1) % 16;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_idx = i[1:0];
      #1;
      chk($sformatf("%s_r%0d", tag, i), dbg_rdata, mregs[i]);
    end
  endtask

  task automatic check_arch(input string tag);
    chk({tag, "_pc"}, pc, mpc);
    chk({tag, "_res"}, result, mres);
    chk({tag, "_z"}, flag_z, mz);
    chk({tag, "_c"}, flag_c, mc);
    chk({tag, "_halted"}, halted, mhalt);
    chk({tag, "_phase"}, phase, 4'b0001);
    check_regs(tag);
  endtask

  task automatic dbg_write(input logic [1:0] idx, input logic [7:0] val);
    dbg_idx = idx; dbg_wdata = val; dbg_we = 1'b1;
    tick();
    dbg_we = 1'b0;
  endtask

  // Entered in FETCH with run=1; executes one instruction and checks timing and state.
  task automatic run_one(input string tag);
    logic [9:0] inst;
    inst = imem[mpc];
    tick();
    chk({tag, "_dec"}, phase, 4'b0010);
    tick();
    tick();
    chk({tag, "_wb"}, phase, 4'b1000);
    chk({tag, "_ret"}, retired, 1'b1);
    tick();
    model_exec(inst);
    chk({tag, "_ret_off"}, retired, 1'b0);
    check_arch(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; dbg_we = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int rcount;
    rst_n = 1'b0; run = 1'b0; dbg_we = 1'b0; dbg_idx = '0; dbg_wdata = '0;
    for (int i = 0; i < 16; i++) imem[i] = '0;

    // reset state
    tick(); tick();
    model_reset();
    chk("rst_retired", retired, 1'b0);
    check_arch("rst");
    rst_n = 1'b1;

    // ADD / SUB with preloaded registers
    imem[0] = enc(4'h1, 2'd0, 2'd1, 2'd2);
    imem[1] = enc(4'h2, 2'd1, 2'd1, 2'd3);
    imem[2] = enc(4'h2, 2'd2, 2'd2, 2'd2);
    dbg_write(2'd0, 8'd4); mregs[0] = 4;
    dbg_write(2'd1, 8'd2); mregs[1] = 2;
    dbg_write(2'd2, 8'd2); mregs[2] = 2;
    dbg_write(2'd3, 8'd4); mregs[3] = 4;
    check_regs("preload");
    run = 1'b1;
    run_one("add");
    chk("add_r0_abs", dbg_rdata, 8'h04);
    run_one("sub_borrow");
    run_one("sub_zero");
    run = 1'b0;

    // carry-out, BZ taken and not taken, LDI, JMP and pc wrap
    imem[3]  = enc(4'h1, 2'd0, 2'd0, 2'd1);
    imem[4]  = enc(4'hA, 2'd0, 2'd1, 2'd1);
    imem[5]  = enc(4'h8, 2'd3, 2'd2, 2'd2);
    imem[6]  = enc(4'h1, 2'd3, 2'd3, 2'd3);
    imem[7]  = enc(4'hA, 2'd0, 2'd3, 2'd0);
    imem[8]  = enc(4'h9, 2'd0, 2'd3, 2'd3);
    imem[15] = enc(4'h0, 2'd0, 2'd0, 2'd0);
    dbg_write(2'd0, 8'hFF); mregs[0] = 255;
    dbg_write(2'd1, 8'h01); mregs[1] = 1;
    run = 1'b1;
    run_one("add_carry");
    chk("add_carry_c_abs", flag_c, 1'b1);
    run_one("bz_taken");
    chk("bz_taken_pc_abs", pc, 4'd5);
    run_one("ldi");
    run_one("add_nz");
    run_one("bz_fall");
    chk("bz_fall_pc_abs", pc, 4'd8);
    run_one("jmp");
    run_one("wrap");
    chk("wrap_pc_abs", pc, 4'd0);

    // HALT at pc=3
    imem[3] = enc(4'hF, 2'd0, 2'd0, 2'd0);
    run_one("p0");
    run_one("p1");
    run_one("p2");
    run_one("halt");
    rcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (retired) rcount++;
    end
    chk("halt_no_retire", rcount, 0);
    chk("halt_pc", pc, 4'd3);
    chk("halt_phase", phase, 4'b0001);
    dbg_write(2'd2, 8'h5A); mregs[2] = 'h5A;
    check_regs("halt_dbg");

    // debug write during EXEC is ignored
    do_reset();
    imem[0] = enc(4'h1, 2'd0, 2'd1, 2'd2);
    dbg_write(2'd1, 8'd3); mregs[1] = 3;
    dbg_write(2'd2, 8'd5); mregs[2] = 5;
    run = 1'b1;
    tick(); tick();
    chk("exec_phase", phase, 4'b0100);
    dbg_idx = 2'd1; dbg_wdata = 8'h77; dbg_we = 1'b1;
    tick();
    dbg_we = 1'b0;
    #1 chk("exec_dbg_ignored", dbg_rdata, 8'd3);
    tick();
    run = 1'b0;
    model_exec(imem[0]);
    check_arch("exec_dbg");

    // reset during EXEC aborts without a write
    imem[1] = enc(4'h1, 2'd0, 2'd2, 2'd2);
    run = 1'b1;
    tick(); tick();
    chk("rst_exec_phase", phase, 4'b0100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; run = 1'b0;
    model_reset();
    chk("rst_exec_retired", retired, 1'b0);
    check_arch("rst_exec");

    // run dropped in DEC: instruction completes, then stall
    dbg_write(2'd1, 8'd3); mregs[1] = 3;
    dbg_write(2'd2, 8'd5); mregs[2] = 5;
    run = 1'b1;
    tick();
    chk("drop_dec", phase, 4'b0010);
    run = 1'b0;
    tick(); tick();
    chk("drop_ret", retired, 1'b1);
    tick();
    model_exec(imem[0]);
    check_arch("drop");
    for (int i = 0; i < 5; i++) tick();
    chk("stall_phase", phase, 4'b0001);
    chk("stall_pc", pc, 4'd1);

    // randomised programs (no HALT) with random stalls and debug writes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      dbg_write(i[1:0], v);
      mregs[i] = v;
    end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 14));
      imem[i] = {rop, 6'($urandom)};
    end
    run = 1'b1;
    for (int n = 0; n < 40; n++) begin
      run_one($sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        logic [1:0] di;
        logic [7:0] dv;
        run = 1'b0;
        di = 2'($urandom); dv = 8'($urandom);
        dbg_write(di, dv);
        mregs[di] = dv;
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) tick();
        chk($sformatf("rnd%0d_stall_pc", n), pc, mpc);
        chk($sformatf("rnd%0d_stall_ph", n), phase, 4'b0001);
        check_regs($sformatf("rnd%0d_stall", n));
        run = 1'b1;
      end
    end
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised successor to the fixed four-register, four-step CPU core: same four-phase (step1..step4) multi-cycle execution, generalised in data width, register count and program-memory depth.
- Adds a flag register, immediate load, jumps and a conditional branch, halt, a run/stall control, and a debug port for register preload and readback, replacing hierarchical pokes from the bench.
- Instantiated by the top-level testbench and any future SoC wrapper.

Parameters:
DATA_W, 8, register/ALU width (>=2)
NREGS, 4, register count, power of two (>=2)
RIDX_W, $clog2(NREGS), register index width (derived)
PC_W, 4, program counter width; imem depth = 2**PC_W
INST_W, 4+3*RIDX_W, instruction width (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  1 = fetch new instructions; 0 = stall at FETCH
imem_addr  out  PC_W  program address, equals pc
imem_data  in  INST_W  instruction, combinational read of imem_addr
dbg_idx  in  RIDX_W  debug register index
dbg_we  in  1  debug register write strobe
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  regs[dbg_idx], combinational
phase  out  4  one-hot {WB,EXEC,DEC,FETCH} (step4..step1)
pc  out  PC_W  program counter
result  out  DATA_W  last ALU result register
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
retired  out  1  one-cycle pulse in WB phase
halted  out  1  HALT executed

Behaviour:
- Reset (rst_n=0 at a rising edge): pc=0, all regs=0, result=0, flag_z=0, flag_c=0, phase=4'b0001, retired=0, halted=0, ir=0. Reset wins over every other event and aborts any instruction in flight with no register write.
- Instruction fields, MSB first: op[3:0], rd, rs1, rs2 (RIDX_W each).
  - imm = {rs1,rs2}, zero-extended or truncated to DATA_W.
  - tgt = {rd,rs1,rs2}, low PC_W bits.
- FETCH:
  - If run=1 and !halted: ir<=imem_data, go to DEC.
  - Otherwise hold in FETCH with pc unchanged.
- DEC: a<=regs[rs1], b<=regs[rs2]; go to EXEC.
- EXEC: compute and latch result; update flags where listed; go to WB. All arithmetic is modulo 2**DATA_W.
  - 0 NOP
  - 1 ADD a+b; C=carry out
  - 2 SUB a-b; C=borrow (a<b)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL a<<1; C=a[MSB]
  - 7 SHR a>>1; C=a[0]
  - 8 LDI imm
  - 9 JMP
  - A BZ
  - B MOV a
  - F HALT
  - C..E NOP
  - Ops 1-7 set Z=(result==0). LDI and MOV leave flags. All other ops leave result and flags unchanged.
- WB: retired=1 for this cycle only; go to FETCH.
  - Ops 1-8 and B write regs[rd]<=result.
  - pc <= tgt for JMP, and for BZ when flag_z=1; otherwise pc <= pc+1, wrapping 2**PC_W-1 -> 0.
  - HALT: pc unchanged, halted<=1. The core then stays in FETCH until reset.
- Latency: exactly 4 cycles per instruction with run held high. Back-to-back instructions get no bypass needed, because DEC reads registers after the previous WB.
- run dropped mid-instruction: the current instruction completes; the stall takes effect at the next FETCH.
- Debug write: honoured only when phase=FETCH and (run=0 or halted=1); ignored otherwise. It can never collide with a WB write.
- Debug read: combinational, valid in any phase. A same-cycle debug write becomes visible on the next cycle.
- Writes to rd=rs1 are legal: DEC has already latched the old value.

Test Plan:
- Preload via dbg: r0=4, r1=2, r2=2, r3=4, run=0, then run=1 with ADD r0,r1,r2 -> retired on the 4th cycle after run rises; r0=4, Z=0, C=0, pc=1.
- SUB r1,r1,r3 (2-4) -> r1=0xFE, C=1, Z=0. Then SUB r2,r2,r2 -> r2=0, Z=1, C=0.
- r0=0xFF, r1=0x01: ADD r0,r0,r1 -> r0=0x00, Z=1, C=1. Next BZ tgt=5 -> pc=5. With Z=0, BZ falls through to pc+1.
- LDI r3,imm=0xA -> r3=0x0A, flags unchanged. JMP tgt=15, then NOP at 15 -> pc wraps to 0.
- HALT at pc=3 -> halted=1, pc stays 3, phase stays 4'b0001, retired pulses once. A dbg write is accepted while halted with run=1. A dbg write during EXEC is ignored.
- Assert rst_n=0 during EXEC of ADD r0 -> r0 not written, all outputs at reset values next cycle. Drop run during DEC -> the instruction retires, then the core holds in FETCH.
